rr_arb_lock: RTL and testbench

- Parametrised successor of the router's 5-port unicast/multicast output arbiter.
- Generalised to NPORT requesters and uses least-recently-granted (LRU) rank priority.
- Multicast requests take precedence over unicast; multicast grants are suppressed by multicast/absorb contention.
- Adds wormhole grant locking: a winner holds the output until its tail flit is accepted. Grants are registered.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/rr_arb_lock_if.sv | 36 +++
 rtl/rr_rank_pick.sv | 44 ++++
 rtl/rr_arb_lock.sv | 168 ++++++++++++++++
 tb/tb_rr_arb_lock.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared types, constants and helpers for the rr_arb_lock
//             output arbiter (state encoding, rank width helper).
//  Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Lock FSM: either free to arbitrate or held by a wormhole packet.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Default port count and the rank a port receives after it releases.
    localparam int ARB_NPORT    = 5;
    localparam int ARB_RANK_LOW = ARB_NPORT - 1;

    // Ceiling log2 with a floor of 1 so a field is never zero bits wide.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_lock_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_lock_if
//  Purpose  : Request/grant bundle between the input ports and the output
//             arbiter.
//  Ports    : u_req, m_req, multab_ct, tail  (requester -> arbiter)
//             grt, grt_id, grt_vld, locked   (arbiter -> requester)
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0  initial release
// ============================================================================
interface rr_arb_lock_if #(
    parameter int NPORT = 5,
    parameter int PW    = 3
) ();

    logic [NPORT-1:0] u_req;
    logic [NPORT-1:0] m_req;
    logic [NPORT-1:0] multab_ct;
    logic [NPORT-1:0] tail;
    logic [NPORT-1:0] grt;
    logic [PW-1:0]    grt_id;
    logic             grt_vld;
    logic             locked;

    modport master (
        output u_req, m_req, multab_ct, tail,
        input  grt, grt_id, grt_vld, locked
    );

    modport slave (
        input  u_req, m_req, multab_ct, tail,
        output grt, grt_id, grt_vld, locked
    );

endinterface
`default_nettype wire

// File: rtl/rr_rank_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_rank_pick
//  Purpose  : Combinational picker: among the requesting ports, return the
//             one with the lowest rank (rank 0 = highest priority).
//  Ports    : i_rank  - per-port rank, a permutation of 0..NPORT-1
//             i_req   - request vector
//             o_oh    - one-hot winner
//             o_id    - encoded winner
//             o_found - at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module rr_rank_pick #(
    parameter int NPORT = 5,
    parameter int PW    = 3
) (
    input  wire logic [NPORT-1:0][PW-1:0] i_rank,
    input  wire logic [NPORT-1:0]         i_req,
    output logic      [NPORT-1:0]         o_oh,
    output logic      [PW-1:0]            o_id,
    output logic                          o_found
);

    logic [PW-1:0] w_best;

    always_comb begin
        o_oh    = '0;
        o_id    = '0;
        o_found = 1'b0;
        w_best  = '1;
        for (int i = 0; i < NPORT; i++) begin
            if (i_req[i] && (!o_found || (i_rank[i] < w_best))) begin
                o_found = 1'b1;
                w_best  = i_rank[i];
                o_id    = PW'(i);
            end
        end
        if (o_found) begin
            o_oh[o_id] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb_lock.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_lock
//  Purpose  : NPORT-way output arbiter with least-recently-granted ranks,
//             multicast-over-unicast precedence, multicast/absorb contention
//             blocking and wormhole grant locking. Grants are registered.
//  Ports    : clk, rst_ (synchronous, active-high)
//             bus (rr_arb_lock_if.slave): u_req, m_req, multab_ct, tail in;
//             grt, grt_id, grt_vld, locked out
//  Options  : ARB_STARVE_EN - unicast starvation counter; after STARVE_LIM
//             cycles of starved unicast, the next arbitration uses u_req.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb_lock
    import arb_pkg::*;
#(
    parameter int NPORT      = ARB_NPORT,
    parameter int PW         = clog2(NPORT),
    parameter int STARVE_LIM = 8
) (
    input wire logic     clk,
    input wire logic     rst_,
    rr_arb_lock_if.slave bus
);

    localparam logic [PW-1:0] c_RANK_LOW = PW'(NPORT - 1);

    arb_state_e               r_state;
    logic [NPORT-1:0][PW-1:0] r_rank;
    logic [PW-1:0]            r_owner;
    logic [NPORT-1:0]         r_grt;
    logic [PW-1:0]            r_grt_id;
    logic                     r_locked;

    logic [NPORT-1:0][PW-1:0] w_rank_rel;
    logic [NPORT-1:0][PW-1:0] w_rank_arb;
    logic                     w_release;
    logic                     w_abort;
    logic                     w_arb_en;
    logic                     w_starve;
    logic                     w_use_m;
    logic [NPORT-1:0]         w_m_oh;
    logic [NPORT-1:0]         w_u_oh;
    logic [PW-1:0]            w_m_id;
    logic [PW-1:0]            w_u_id;
    logic                     w_m_found;
    logic                     w_u_found;
    logic [NPORT-1:0]         w_win_oh;
    logic [PW-1:0]            w_win_id;
    logic                     w_grant_new;

    // Tail beats abort: a tail flit accepted on the same edge the owner drops
    // its request still counts as a completed packet.
    assign w_release = (r_state == ARB_LOCK) && bus.tail[r_owner];
    assign w_abort   = (r_state == ARB_LOCK) && !bus.tail[r_owner]
                       && !(bus.u_req[r_owner] || bus.m_req[r_owner]);
    assign w_arb_en  = (r_state == ARB_IDLE) || w_release;

    // Ranks after the current owner releases: owner drops to the bottom and
    // everyone that was below it moves up one place.
    always_comb begin
        w_rank_rel = r_rank;
        for (int j = 0; j < NPORT; j++) begin
            if (PW'(j) == r_owner) begin
                w_rank_rel[j] = c_RANK_LOW;
            end else if (r_rank[j] > r_rank[r_owner]) begin
                w_rank_rel[j] = r_rank[j] - PW'(1);
            end
        end
    end

    // Re-arbitration on a release edge already sees the owner at the bottom,
    // giving back-to-back packets without a bubble.
    assign w_rank_arb = w_release ? w_rank_rel : r_rank;

    rr_rank_pick #(.NPORT(NPORT), .PW(PW)) u_pick_m (
        .i_rank  (w_rank_arb),
        .i_req   (bus.m_req),
        .o_oh    (w_m_oh),
        .o_id    (w_m_id),
        .o_found (w_m_found)
    );

    rr_rank_pick #(.NPORT(NPORT), .PW(PW)) u_pick_u (
        .i_rank  (w_rank_arb),
        .i_req   (bus.u_req),
        .o_oh    (w_u_oh),
        .o_id    (w_u_id),
        .o_found (w_u_found)
    );

`ifdef ARB_STARVE_EN
    localparam int CW = clog2(STARVE_LIM + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          r_uc_act;
    logic          w_uc_grant;

    assign w_starve   = (r_starve_cnt == CW'(STARVE_LIM)) && (|bus.u_req);
    assign w_uc_grant = w_arb_en && w_grant_new && !w_use_m;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_starve_cnt <= '0;
            r_uc_act     <= 1'b0;
        end else begin
            if (w_arb_en || w_abort) begin
                r_uc_act <= w_uc_grant;
            end
            if (w_uc_grant) begin
                r_starve_cnt <= '0;
            end else if ((|bus.u_req) && (|bus.m_req) && !r_uc_act
                         && (r_starve_cnt != CW'(STARVE_LIM))) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end
        end
    end
`else
    // No starvation relief: multicast keeps strict precedence. The limit only
    // matters when the counter is built in, and is always positive.
    assign w_starve = (STARVE_LIM < 0);
`endif

    assign w_use_m  = (|bus.m_req) && !w_starve;
    assign w_win_oh = w_use_m ? w_m_oh : w_u_oh;
    assign w_win_id = w_use_m ? w_m_id : w_u_id;

    // A blocked multicast winner stalls the whole output for this cycle; it
    // neither falls through to the next multicast port nor to unicast.
    assign w_grant_new = (w_use_m ? w_m_found : w_u_found)
                         && !(w_use_m && (|(w_m_oh & bus.multab_ct)));

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_grt    <= '0;
            r_grt_id <= '0;
            r_locked <= 1'b0;
            for (int i = 0; i < NPORT; i++) begin
                r_rank[i] <= PW'(NPORT - 1 - i);
            end
        end else begin
            if (w_release) begin
                r_rank <= w_rank_rel;
            end
            if (w_arb_en && w_grant_new) begin
                r_state  <= ARB_LOCK;
                r_owner  <= w_win_id;
                r_grt    <= w_win_oh;
                r_grt_id <= w_win_id;
                r_locked <= 1'b1;
            end else if (w_arb_en || w_abort) begin
                r_state  <= ARB_IDLE;
                r_grt    <= '0;
                r_grt_id <= '0;
                r_locked <= 1'b0;
            end
        end
    end

    assign bus.grt     = r_grt;
    assign bus.grt_id  = r_grt_id;
    assign bus.grt_vld = |r_grt;
    assign bus.locked  = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb_lock
//  Purpose  : Directed self-checking bench for rr_arb_lock (NPORT=5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb_lock;

    localparam int NPORT = 5;
    localparam int PW    = 3;

    logic clk = 1'b0;
    logic rst_;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rr_arb_lock_if #(.NPORT(NPORT), .PW(PW)) bus ();

    rr_arb_lock #(.NPORT(NPORT), .PW(PW), .STARVE_LIM(8)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NPORT-1:0] u, input logic [NPORT-1:0] m,
                         input logic [NPORT-1:0] ct, input logic [NPORT-1:0] t);
        bus.u_req     = u;
        bus.m_req     = m;
        bus.multab_ct = ct;
        bus.tail      = t;
    endtask

    task automatic do_reset();
        drive('0, '0, '0, '0);
        rst_ = 1'b1;
        tick();
        tick();
        rst_ = 1'b0;
    endtask

    initial begin
        logic [NPORT-1:0] alt [4];
        int               first_hit;

        alt[0] = 5'b00010; alt[1] = 5'b00001;
        alt[2] = 5'b00010; alt[3] = 5'b00001;

        // Reset state
        do_reset();
        check_eq("rst_grt",    32'(bus.grt),     32'h0);
        check_eq("rst_id",     32'(bus.grt_id),  32'h0);
        check_eq("rst_vld",    32'(bus.grt_vld), 32'h0);
        check_eq("rst_locked", 32'(bus.locked),  32'h0);

        // 1: two unicast single-flit requesters alternate every cycle
        drive(5'b00011, '0, '0, 5'b11111);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("alt_grt%0d", i), 32'(bus.grt), 32'(alt[i]));
        end
        check_eq("alt_id",  32'(bus.grt_id),  32'd0);
        check_eq("alt_vld", 32'(bus.grt_vld), 32'd1);

        // 2: multicast beats a higher-ranked unicast
        do_reset();
        drive(5'b10000, 5'b00100, '0, 5'b11111);
        tick();
        check_eq("mc_prec_grt", 32'(bus.grt),    32'h04);
        check_eq("mc_prec_id",  32'(bus.grt_id), 32'd2);

        // 3: contention on the multicast winner blocks everything
        do_reset();
        drive(5'b00001, 5'b01000, 5'b01000, '0);
        tick();
        check_eq("ct_grt",    32'(bus.grt),    32'h0);
        check_eq("ct_locked", 32'(bus.locked), 32'h0);
        tick();
        check_eq("ct_grt2",   32'(bus.grt),    32'h0);
        bus.multab_ct = '0;
        tick();
        check_eq("ct_clr_grt", 32'(bus.grt),   32'h08);

        // 4: lock held against competing requests, then released on tail
        do_reset();
        drive(5'b00100, '0, '0, '0);
        tick();
        check_eq("lk_first", 32'(bus.grt), 32'h04);
        bus.u_req = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("lk_hold%0d", i), 32'(bus.grt), 32'h04);
            check_eq($sformatf("lk_lock%0d", i), 32'(bus.locked), 32'h1);
        end
        bus.tail = 5'b00100;
        tick();
        check_eq("lk_rel_grt", 32'(bus.grt),    32'h10);
        check_eq("lk_rel_id",  32'(bus.grt_id), 32'd4);
        // ranks now 4:0 3:1 1:2 0:3 2:4; port 4 releasing hands over to port 3
        bus.tail = 5'b10000;
        tick();
        check_eq("lk_rel2_grt", 32'(bus.grt), 32'h08);

        // 5: abort mid-packet drops the grant without touching ranks
        do_reset();
        drive(5'b00010, '0, '0, '0);
        tick();
        check_eq("ab_grt",    32'(bus.grt), 32'h02);
        bus.u_req = '0;
        tick();
        check_eq("ab_grt0",   32'(bus.grt),     32'h0);
        check_eq("ab_vld0",   32'(bus.grt_vld), 32'h0);
        check_eq("ab_locked", 32'(bus.locked),  32'h0);
        // port 1 still outranks port 0 since no rank update happened
        bus.u_req = 5'b00011;
        tick();
        check_eq("ab_rank", 32'(bus.grt), 32'h02);
        // tail and abort together: tail wins, port 1 goes to the bottom
        bus.u_req = 5'b00001;
        bus.tail  = 5'b00010;
        tick();
        check_eq("ab_tail_wins", 32'(bus.grt), 32'h01);

        // 6: continuous multicast against a waiting unicast
        do_reset();
        drive(5'b00010, 5'b00001, '0, 5'b11111);
        first_hit = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.grt[1] && first_hit == 0) begin
                first_hit = c;
            end
            if (first_hit != 0) begin
                break;
            end
        end
`ifdef ARB_STARVE_EN
        check_eq("stv_hit_cycle", 32'(first_hit), 32'd9);
        tick();
        check_eq("stv_back_mc", 32'(bus.grt), 32'h01);
`else
        check_eq("stv_never", 32'(first_hit), 32'd0);
        check_eq("stv_mc_grt", 32'(bus.grt), 32'h01);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
